// File: rtl/grant_owner_ctrl.sv
// grant_owner_ctrl: turns a level-based arbiter grant into a counted ownership
// session (accept, per-beat ack, completion/abort pulse, mandatory re-arm).
// Optional build macro: GRANT_OWNER_WDOG_EN adds an idle watchdog in OWN that
// aborts the session after TIMEOUT consecutive cycles without a beat.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no session; waiting for a well-formed grant
// OWN      | session active; beats acked and counted
// DONE     | one-cycle completion pulse on done[owner], aborted qualifies it
// WAIT_REL | waiting for the owner's grant to drop so it is not re-accepted
module grant_owner_ctrl #(
   parameter int LEN_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       i_grant,
   input  logic [1:0]       i_grant_num,
   input  logic             i_available,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_beat_valid,
   input  logic             i_release,
   output logic             o_owner_valid,
   output logic [1:0]       o_owner_num,
   output logic [3:0]       o_ack,
   output logic [LEN_W-1:0] o_beat_cnt,
   output logic [3:0]       o_done,
   output logic             o_aborted,
   output logic             o_grant_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWN      = 2'd1,
      DONE     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_owner_num, w_owner_num_nxt;
   logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
   logic [LEN_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
   logic             r_aborted, w_aborted_nxt;
   logic             r_grant_err, w_grant_err_nxt;

   logic             w_grant_onehot;
   logic             w_grant_ok;
   logic             w_own_grant;
   logic             w_beat;
   logic             w_wdog_fire;

   // Accept only a single-bit grant whose encoded index agrees with it.
   assign w_grant_onehot = (i_grant != 4'b0000) && ((i_grant & (i_grant - 4'b0001)) == 4'b0000);
   assign w_grant_ok     = !i_available && w_grant_onehot && (i_grant == (4'b0001 << i_grant_num));
   assign w_own_grant    = i_grant[r_owner_num];
   // A beat is lost (not acked) in the cycle the owner's grant disappears.
   assign w_beat         = (r_state == OWN) && i_beat_valid && w_own_grant;

`ifdef GRANT_OWNER_WDOG_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;

   assign w_wdog_fire = !i_beat_valid && (r_idle_cnt == IDLE_W'(TIMEOUT - 1));

   // Idle-cycle counter: restarts on accept and on every beat.
   always_comb begin
      w_idle_cnt_nxt = r_idle_cnt;
      if (r_state == IDLE) begin
         w_idle_cnt_nxt = '0;
      end else if (r_state == OWN) begin
         w_idle_cnt_nxt = i_beat_valid ? '0 : (r_idle_cnt + 1'b1);
      end
   end

   // Idle counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_idle_cnt <= '0;
      else        r_idle_cnt <= w_idle_cnt_nxt;
   end
`else
   assign w_wdog_fire = 1'b0;
`endif

   // Next-state and session bookkeeping.
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_num_nxt = r_owner_num;
      w_remaining_nxt = r_remaining;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_aborted_nxt   = r_aborted;
      w_grant_err_nxt = r_grant_err;
      case (r_state)
         IDLE: begin
            if (w_grant_ok) begin
               w_owner_num_nxt = i_grant_num;
               w_remaining_nxt = i_len;
               w_beat_cnt_nxt  = '0;
               w_aborted_nxt   = 1'b0;
               w_state_nxt     = (i_len == '0) ? DONE : OWN;
            end else if (!i_available) begin
               w_grant_err_nxt = 1'b1;
            end
         end
         OWN: begin
            if (!w_own_grant) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = DONE;
            end else begin
               if (w_beat) begin
                  w_remaining_nxt = r_remaining - 1'b1;
                  w_beat_cnt_nxt  = r_beat_cnt + 1'b1;
               end
               if ((w_beat && (r_remaining == LEN_W'(1))) || i_release) begin
                  w_aborted_nxt = 1'b0;
                  w_state_nxt   = DONE;
               end else if (w_wdog_fire) begin
                  w_aborted_nxt = 1'b1;
                  w_state_nxt   = DONE;
               end
            end
         end
         DONE: begin
            w_state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (!w_own_grant || i_available) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and session registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_owner_num <= 2'd0;
         r_remaining <= '0;
         r_beat_cnt  <= '0;
         r_aborted   <= 1'b0;
         r_grant_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner_num <= w_owner_num_nxt;
         r_remaining <= w_remaining_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_aborted   <= w_aborted_nxt;
         r_grant_err <= w_grant_err_nxt;
      end
   end

   assign o_owner_valid = (r_state == OWN);
   assign o_owner_num   = r_owner_num;
   assign o_ack         = w_beat ? (4'b0001 << r_owner_num) : 4'b0000;
   assign o_beat_cnt    = r_beat_cnt;
   assign o_done        = (r_state == DONE) ? (4'b0001 << r_owner_num) : 4'b0000;
   assign o_aborted     = (r_state == DONE) && r_aborted;
   assign o_grant_err   = r_grant_err;

endmodule

// File: tb/tb_grant_owner_ctrl.sv
// Bench for grant_owner_ctrl: expected completions are queued as sessions are
// driven and compared when the DUT pulses done.
module tb_grant_owner_ctrl;

   localparam int LEN_W = 5;
   localparam int TMO   = 4;

   logic             clk;
   logic             rst_n;
   logic [3:0]       grant;
   logic [1:0]       gnum;
   logic             avail;
   logic [LEN_W-1:0] len;
   logic             beat;
   logic             rel;
   logic             ov;
   logic [1:0]       on;
   logic [3:0]       ack;
   logic [LEN_W-1:0] cnt;
   logic [3:0]       done;
   logic             ab;
   logic             err;

   typedef struct {
      logic [3:0]       done;
      logic             ab;
      logic [LEN_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   ov_cycles;

   grant_owner_ctrl #(.LEN_W(LEN_W), .TIMEOUT(TMO)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_grant      (grant),
      .i_grant_num  (gnum),
      .i_available  (avail),
      .i_len        (len),
      .i_beat_valid (beat),
      .i_release    (rel),
      .o_owner_valid(ov),
      .o_owner_num  (on),
      .o_ack        (ack),
      .o_beat_cnt   (cnt),
      .o_done       (done),
      .o_aborted    (ab),
      .o_grant_err  (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic a, input logic [LEN_W-1:0] c);
      exp_t e;
      e.done = d;
      e.ab   = a;
      e.cnt  = c;
      sb_q.push_back(e);
   endtask

   task automatic drop_grant();
      grant = 4'b0000;
      gnum  = 2'd0;
      avail = 1'b1;
      beat  = 1'b0;
      rel   = 1'b0;
      step();
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ov", ov, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Completion monitor: every done pulse must match the oldest queued session.
   always @(negedge clk) begin
      if (rst_n && (done != 4'b0000)) begin
         if (sb_q.size() == 0) begin
            chk("done_unexpected", done, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("done", done, e.done);
            chk("aborted", ab, e.ab);
            chk("done_cnt", cnt, e.cnt);
            chk("done_ov", ov, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      grant = 4'b0000;
      gnum  = 2'd0;
      avail = 1'b1;
      len   = '0;
      beat  = 1'b0;
      rel   = 1'b0;
      #1;
      chk("reset_ov", ov, 0);
      chk("reset_on", on, 0);
      chk("reset_ack", ack, 0);
      chk("reset_cnt", cnt, 0);
      chk("reset_done", done, 0);
      chk("reset_ab", ab, 0);
      chk("reset_err", err, 0);
      step();
      rst_n = 1'b1;
      step();

      // Owner 0, three back-to-back beats, grant held afterwards.
      grant = 4'b0001; gnum = 2'd0; avail = 1'b0; len = 5'd3;
      step();
      chk("t1_ov", ov, 1);
      chk("t1_on", on, 0);
      push(4'b0001, 1'b0, 5'd3);
      for (int i = 0; i < 3; i++) begin
         beat = 1'b1;
         #1;
         chk("t1_ack", ack, 4'b0001);
         step();
         chk("t1_cnt", cnt, i + 1);
      end
      beat = 1'b0;
      chk("t1_ov_done", ov, 0);
      repeat (5) step();
      chk("t1_no_reaccept", ov, 0);
      chk("t1_hold_cnt", cnt, 3);
      drop_grant();

      // Owner 2 preempted after two beats, then owner 0 after one IDLE cycle.
      grant = 4'b0100; gnum = 2'd2; avail = 1'b0; len = 5'd5;
      step();
      chk("t2_on", on, 2);
      push(4'b0100, 1'b1, 5'd2);
      for (int i = 0; i < 2; i++) begin
         beat = 1'b1;
         #1;
         chk("t2_ack", ack, 4'b0100);
         step();
      end
      grant = 4'b0001; gnum = 2'd0;
      #1;
      chk("t2_ack_lost", ack, 0);
      step();
      beat = 1'b0;
      chk("t2_cnt", cnt, 2);
      step();
      chk("t2_wait_ov", ov, 0);
      step();
      chk("t2_idle_ov", ov, 0);
      step();
      chk("t2_new_ov", ov, 1);
      chk("t2_new_on", on, 0);
      chk("t2_new_cnt", cnt, 0);
      push(4'b0001, 1'b0, 5'd0);
      rel = 1'b1;
      step();
      rel = 1'b0;
      drop_grant();

      // Owner 3 releases on beat 4.
      grant = 4'b1000; gnum = 2'd3; avail = 1'b0; len = 5'd8;
      step();
      push(4'b1000, 1'b0, 5'd4);
      for (int i = 0; i < 4; i++) begin
         beat = 1'b1;
         rel  = (i == 3);
         #1;
         chk("t3_ack", ack, 4'b1000);
         step();
      end
      beat = 1'b0; rel = 1'b0;
      chk("t3_cnt", cnt, 4);
      chk("t3_ov", ov, 0);
      drop_grant();

      // Malformed grants.
      grant = 4'b0110; gnum = 2'd1; avail = 1'b0;
      step();
      chk("t4a_ov", ov, 0);
      chk("t4a_err", err, 1);
      drop_grant();
      chk("t4a_err_held", err, 1);
      do_reset();
      grant = 4'b0010; gnum = 2'd3; avail = 1'b0;
      step();
      chk("t4b_ov", ov, 0);
      chk("t4b_err", err, 1);
      drop_grant();
      repeat (3) step();
      chk("t4b_err_held", err, 1);
      do_reset();

      // Zero-length session.
      grant = 4'b0010; gnum = 2'd1; avail = 1'b0; len = 5'd0;
      push(4'b0010, 1'b0, 5'd0);
      step();
      beat = 1'b1;
      #1;
      chk("t5_ack", ack, 0);
      chk("t5_ov", ov, 0);
      chk("t5_done", done, 4'b0010);
      beat = 1'b0;
      drop_grant();

      // Grant held with no beats.
      grant = 4'b0001; gnum = 2'd0; avail = 1'b0; len = 5'd31;
      step();
`ifdef GRANT_OWNER_WDOG_EN
      push(4'b0001, 1'b1, 5'd0);
      repeat (TMO - 1) step();
      chk("t6_ov_before", ov, 1);
      step();
      chk("t6_ov_wdog", ov, 0);
      drop_grant();
      grant = 4'b0001; gnum = 2'd0; avail = 1'b0;
      step();
`else
      ov_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         if (ov) ov_cycles++;
         step();
      end
      chk("t6_ov_cycles", ov_cycles, 100);
`endif
      beat = 1'b1;
      step();
      beat = 1'b0;
      chk("t7_cnt_pre", cnt, 1);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_ov", ov, 0);
      chk("t7_rst_cnt", cnt, 0);
      chk("t7_rst_done", done, 0);
      step();
      step();
      rst_n = 1'b1;
      drop_grant();

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
